// File: rtl/bitwise_tx.sv
// bitwise_tx: MSB-first parallel-to-serial transmitter with load handshake; optional even parity bit via BITWISE_TX_PARITY_EN
module bitwise_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load,
  input  logic             load_en,
  input  logic             en,
  output logic             ready,
  output logic             q,
  output logic             q_valid,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
`ifdef BITWISE_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic par, par_d;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
  state_t state, state_d;
  logic [WIDTH-1:0] sr, sr_d;
  logic [CW-1:0] cnt, cnt_d;
  logic done_d;
  // state, shift register, counter and done pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      done <= 1'b0;
`ifdef BITWISE_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_d;
      sr <= sr_d;
      cnt <= cnt_d;
      done <= done_d;
`ifdef BITWISE_TX_PARITY_EN
      par <= par_d;
`endif
    end
  end
  // next-state: load only from IDLE, advance only on en, done registered from the final consuming en
  always_comb begin
    state_d = state;
    sr_d = sr;
    cnt_d = cnt;
    done_d = 1'b0;
`ifdef BITWISE_TX_PARITY_EN
    par_d = par;
`endif
    case (state)
      IDLE: if (load_en) begin
        state_d = SHIFT;
        sr_d = load;
        cnt_d = CW'(WIDTH - 1);
`ifdef BITWISE_TX_PARITY_EN
        par_d = ^load;
`endif
      end
      SHIFT: if (en) begin
        if (cnt != '0) begin
          sr_d = {sr[WIDTH-2:0], 1'b0};
          cnt_d = cnt - CW'(1);
        end else begin
`ifdef BITWISE_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
          done_d = 1'b1;
`endif
        end
      end
`ifdef BITWISE_TX_PARITY_EN
      PARITY: if (en) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded from registered state only
  always_comb begin
    ready = state == IDLE;
    q_valid = state != IDLE;
`ifdef BITWISE_TX_PARITY_EN
    q = state == SHIFT ? sr[WIDTH-1] : state == PARITY ? par : 1'b0;
`else
    q = state == SHIFT ? sr[WIDTH-1] : 1'b0;
`endif
  end
endmodule

// File: tb/tb_bitwise_tx.sv
// tb_bitwise_tx: directed self-checking bench for bitwise_tx (WIDTH=8)
module tb_bitwise_tx;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] load;
  logic load_en;
  logic en;
  logic ready, q, q_valid, done;
  int checks = 0;
  int errors = 0;
  bitwise_tx #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .load(load), .load_en(load_en), .en(en),
    .ready(ready), .q(q), .q_valid(q_valid), .done(done)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_q"}, 32'(q), 32'd0);
    check({tag, "_q_valid"}, 32'(q_valid), 32'd0);
  endtask
  // Called at a negedge; leaves the bench at the negedge of the done cycle.
  task automatic tx_frame(input logic [7:0] w, input int per, input logic intrude, input string tag);
    load = w;
    load_en = 1'b1;
    en = per == 1;
    @(negedge clk);
    load_en = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      for (int k = 0; k < per; k++) begin
        check({tag, "_q"}, 32'(q), 32'(w[i]));
        check({tag, "_q_valid"}, 32'(q_valid), 32'd1);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_done_low"}, 32'(done), 32'd0);
        load_en = intrude && i > 0;
        if (intrude) load = 8'hFF;
        en = k == per - 1;
        @(negedge clk);
      end
    end
`ifdef BITWISE_TX_PARITY_EN
    for (int k = 0; k < per; k++) begin
      check({tag, "_parity"}, 32'(q), 32'(^w));
      check({tag, "_parity_valid"}, 32'(q_valid), 32'd1);
      check({tag, "_done_low"}, 32'(done), 32'd0);
      en = k == per - 1;
      @(negedge clk);
    end
`endif
    en = 1'b0;
    load_en = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    idle_outputs({tag, "_end"});
  endtask
  initial begin
    reset = 1'b1;
    load = '0;
    load_en = 1'b0;
    en = 1'b0;
    #1;
    idle_outputs("rst0");
    check("rst0_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    idle_outputs("idle_en");
    en = 1'b0;
    #2 reset = 1'b1;
    #1 idle_outputs("rst_idle");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tx_frame(8'h80, 1, 1'b0, "f80");
    @(negedge clk);
    check("f80_done_pulse", 32'(done), 32'd0);
    tx_frame(8'hA5, 4, 1'b0, "fa5");
    @(negedge clk);
    tx_frame(8'h3C, 1, 1'b1, "f3c");
    @(negedge clk);
    check("f3c_single_done", 32'(done), 32'd0);
    idle_outputs("f3c_after");
    load = 8'hF0;
    load_en = 1'b1;
    en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_bit4", 32'(q), 32'd1);
    check("abort_valid", 32'(q_valid), 32'd1);
    #2 reset = 1'b1;
    #1 idle_outputs("rst_mid");
    check("rst_mid_done", 32'(done), 32'd0);
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    en = 1'b0;
    tx_frame(8'h0F, 1, 1'b0, "f0f");
    tx_frame(8'h55, 1, 1'b0, "f55");
    tx_frame(8'hC3, 2, 1'b0, "fc3");
    @(negedge clk);
    check("final_done_low", 32'(done), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
